// File: rtl/pea_core_ctrl.sv
// Execution controller for the Polynomial Evaluation Accelerator: fetches commands,
// loads coefficients and evaluates polynomials by Horner's method.
module pea_core_ctrl #(
  parameter int unsigned word_size  = 16,
  parameter int unsigned max_coeffs = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [word_size-1:0] cmd_data,
  input  logic [word_size-1:0] in_data,
  output logic                 rd_en_command,
  output logic                 rd_en_data,
  output logic [1:0]           next_mode_out,
  output logic [7:0]           mode_out,
  output logic [4:0]           arg2_out,
  output logic                 result_wr_en,
  output logic [word_size-1:0] result_data,
  output logic                 status_wr_en,
  output logic [word_size-1:0] status_data
);
  localparam int unsigned NW = $clog2(max_coeffs + 1);
  localparam int unsigned IW = (max_coeffs > 1) ? $clog2(max_coeffs) : 1;

  localparam logic [7:0] MODE_STP = 8'd0;
  localparam logic [7:0] MODE_EVP = 8'd1;
  localparam logic [7:0] MODE_EVB = 8'd2;
  localparam logic [7:0] MODE_RST = 8'd3;

  localparam logic [1:0] NM_SETUP = 2'b00;
  localparam logic [1:0] NM_INSTR = 2'b01;

  localparam logic [word_size-1:0] ST_BAD_MODE = word_size'(16'hFFFF);
  localparam logic [word_size-1:0] ST_BAD_STP  = word_size'(16'hFFFE);
  localparam logic [word_size-1:0] ST_NO_POLY  = word_size'(16'hFFFD);

  typedef enum logic [2:0] {
    S_SETUP, S_WAIT, S_LOAD, S_XPOP, S_HORN, S_NEXT, S_DONE
  } state_t;

  state_t               state;
  logic [word_size-1:0] c [max_coeffs];
  logic [NW-1:0]        n;
  logic [4:0]           k;
  logic [4:0]           rem;
  logic [IW-1:0]        idx;
  logic [word_size-1:0] acc;
  logic [word_size-1:0] x;
  logic                 stp_ok;
  logic                 is_evb;

  logic [word_size-1:0] prod;
  logic [word_size-1:0] horner;
  logic                 x_done;
  logic [word_size-1:0] fin_val;

  // One Horner step; product truncated to the word before the add
  always_comb begin
    prod    = acc * x;
    horner  = prod + c[idx];
    x_done  = ((state == S_XPOP) && (n == NW'(1))) || ((state == S_HORN) && (idx == '0));
    fin_val = (state == S_HORN) ? horner : c[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_SETUP;
      next_mode_out <= NM_SETUP;
      mode_out      <= '0;
      arg2_out      <= '0;
      rd_en_command <= 1'b0;
      rd_en_data    <= 1'b0;
      result_wr_en  <= 1'b0;
      result_data   <= '0;
      status_wr_en  <= 1'b0;
      status_data   <= '0;
      n             <= '0;
      k             <= '0;
      rem           <= '0;
      idx           <= '0;
      acc           <= '0;
      x             <= '0;
      stp_ok        <= 1'b0;
      is_evb        <= 1'b0;
      for (int i = 0; i < int'(max_coeffs); i++) c[i] <= '0;
    end else begin
      rd_en_command <= 1'b0;
      rd_en_data    <= 1'b0;
      result_wr_en  <= 1'b0;
      status_wr_en  <= 1'b0;
      case (state)
        S_SETUP: if (enable) begin
          rd_en_command <= 1'b1;
          mode_out      <= cmd_data[7:0];
          arg2_out      <= cmd_data[12:8];
          next_mode_out <= NM_INSTR;
          state         <= S_WAIT;
        end
        S_WAIT: if (enable) begin
          k <= '0;
          case (mode_out)
            MODE_STP: begin
              stp_ok <= (arg2_out != 5'd0) && (32'(arg2_out) <= max_coeffs);
              if (arg2_out == 5'd0) begin
                status_wr_en <= 1'b1;
                status_data  <= ST_BAD_STP;
                state        <= S_DONE;
              end else begin
                rd_en_data <= 1'b1;
                state      <= S_LOAD;
              end
            end
            MODE_EVP: begin
              is_evb     <= 1'b0;
              rem        <= 5'd1;
              rd_en_data <= 1'b1;
              state      <= S_XPOP;
            end
            MODE_EVB: begin
              is_evb <= 1'b1;
              rem    <= arg2_out;
              if (arg2_out == 5'd0) begin
                status_wr_en <= 1'b1;
                status_data  <= '0;
                state        <= S_DONE;
              end else begin
                rd_en_data <= 1'b1;
                state      <= S_XPOP;
              end
            end
            MODE_RST: begin
              for (int i = 0; i < int'(max_coeffs); i++) c[i] <= '0;
              n            <= '0;
              status_wr_en <= 1'b1;
              status_data  <= '0;
              state        <= S_DONE;
            end
            default: begin
              status_wr_en <= 1'b1;
              status_data  <= ST_BAD_MODE;
              state        <= S_DONE;
            end
          endcase
        end
        // Out-of-range loads still drain their tokens but leave c and n untouched
        S_LOAD: begin
          if (stp_ok) c[IW'(k)] <= in_data;
          if (k == arg2_out - 5'd1) begin
            status_wr_en <= 1'b1;
            status_data  <= stp_ok ? word_size'(arg2_out) : ST_BAD_STP;
            if (stp_ok) n <= NW'(arg2_out);
            state <= S_DONE;
          end else begin
            k          <= k + 5'd1;
            rd_en_data <= 1'b1;
          end
        end
        S_XPOP: begin
          x <= in_data;
          if (n == '0) begin
            if (rem == 5'd1) begin
              status_wr_en <= 1'b1;
              status_data  <= ST_NO_POLY;
              state        <= S_DONE;
            end else begin
              rem        <= rem - 5'd1;
              rd_en_data <= 1'b1;
            end
          end else if (n != NW'(1)) begin
            acc   <= c[IW'(n - NW'(1))];
            idx   <= IW'(n - NW'(2));
            state <= S_HORN;
          end
        end
        S_HORN: if (idx != '0) begin
          acc <= horner;
          idx <= idx - IW'(1);
        end
        S_NEXT: begin
          rd_en_data <= 1'b1;
          state      <= S_XPOP;
        end
        S_DONE: begin
          next_mode_out <= NM_SETUP;
          state         <= S_SETUP;
        end
        default: state <= S_SETUP;
      endcase
      // Completion of one x: push its result, plus the status on the last one
      if (x_done) begin
        result_wr_en <= 1'b1;
        result_data  <= fin_val;
        if (rem == 5'd1) begin
          status_wr_en <= 1'b1;
          status_data  <= is_evb ? word_size'(arg2_out) : '0;
          state        <= S_DONE;
        end else begin
          rem   <= rem - 5'd1;
          state <= S_NEXT;
        end
      end
    end
  end
endmodule

// File: tb/tb_pea_core_ctrl.sv
// Directed bench for pea_core_ctrl: FWFT FIFO models feed the controller and a
// negedge monitor logs every pop and push with its cycle number.
module tb_pea_core_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cmd_data;
  logic [15:0] in_data;
  logic        rd_en_command;
  logic        rd_en_data;
  logic [1:0]  next_mode_out;
  logic [7:0]  mode_out;
  logic [4:0]  arg2_out;
  logic        result_wr_en;
  logic [15:0] result_data;
  logic        status_wr_en;
  logic [15:0] status_data;

  pea_core_ctrl #(.word_size(16), .max_coeffs(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_data(cmd_data), .in_data(in_data),
    .rd_en_command(rd_en_command), .rd_en_data(rd_en_data),
    .next_mode_out(next_mode_out), .mode_out(mode_out), .arg2_out(arg2_out),
    .result_wr_en(result_wr_en), .result_data(result_data),
    .status_wr_en(status_wr_en), .status_data(status_data)
  );

  always #5 clk = ~clk;

  logic [15:0] cmd_mem [64];
  logic [15:0] dat_mem [128];
  int cmd_wp = 0, cmd_rp = 0, dat_wp = 0, dat_rp = 0;
  int cyc = 0;
  logic go = 1'b0;

  // Enable stage model: commands gate SETUP, data is always preloaded
  always_comb begin
    cmd_data = cmd_mem[cmd_rp[5:0]];
    in_data  = dat_mem[dat_rp[6:0]];
    enable   = go && ((next_mode_out == 2'b00) ? (cmd_wp != cmd_rp) : 1'b1);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_command) cmd_rp <= cmd_rp + 1;
    if (rd_en_data)    dat_rp <= dat_rp + 1;
  end

  logic [15:0] res_val [256];
  int          res_cyc [256];
  logic [15:0] st_val  [256];
  int          st_cyc  [256];
  int          dpop_cyc [256];
  int nres = 0, nstat = 0, ndpop = 0, ncpop = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (result_wr_en) begin res_val[nres] = result_data; res_cyc[nres] = cyc; nres++; end
    if (status_wr_en) begin st_val[nstat] = status_data; st_cyc[nstat] = cyc; nstat++; end
    if (rd_en_data) begin dpop_cyc[ndpop] = cyc; ndpop++; end
    if (rd_en_command) ncpop++;
    if (rd_en_command && rd_en_data) both_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic push_cmd(input logic [15:0] w);
    cmd_mem[cmd_wp[5:0]] = w;
    cmd_wp++;
  endtask

  task automatic push_data(input logic [15:0] w);
    dat_mem[dat_wp[6:0]] = w;
    dat_wp++;
  endtask

  task automatic wait_status(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (nstat > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; go = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (next_mode_out !== 2'b00) begin n_bad++; $display("FAIL rst_next_mode: got %0h expected 0", next_mode_out); end
    n_cmp++; if (mode_out !== 8'd0) begin n_bad++; $display("FAIL rst_mode: got %0h expected 0", mode_out); end
    n_cmp++; if (arg2_out !== 5'd0) begin n_bad++; $display("FAIL rst_arg2: got %0h expected 0", arg2_out); end
    n_cmp++; if ({rd_en_command, rd_en_data, result_wr_en, status_wr_en} !== 4'b0) begin
      n_bad++; $display("FAIL rst_strobes: got %b expected 0000", {rd_en_command, rd_en_data, result_wr_en, status_wr_en}); end
    n_cmp++; if ({result_data, status_data} !== 32'd0) begin
      n_bad++; $display("FAIL rst_data: got %0h expected 0", {result_data, status_data}); end
    rst = 1'b0;
    push_cmd(16'h0003);
    repeat (6) @(negedge clk);
    n_cmp++; if (nres + nstat + ndpop + ncpop !== 0) begin
      n_bad++; $display("FAIL idle_no_strobes: got %0d events expected 0", nres + nstat + ndpop + ncpop); end
    go = 1'b1;
    wait_status(0, ok);
    n_cmp++; if (!ok || st_val[0] !== 16'd0 || ndpop !== 0) begin
      n_bad++; $display("FAIL rst_cmd: got ok=%0d status %0h pops %0d expected ok=1 status 0 pops 0", ok, st_val[0], ndpop); end
  endtask

  task automatic test_stp_evp();
    int s0, r0, p0; bit ok;
    s0 = nstat; r0 = nres; p0 = ndpop;
    push_data(16'd1); push_data(16'd2); push_data(16'd3);
    push_cmd(16'h0300);
    wait_status(s0, ok);
    n_cmp++; if (!ok || st_val[s0] !== 16'd3) begin n_bad++; $display("FAIL stp3_status: got %0h expected 3", st_val[s0]); end
    n_cmp++; if (ndpop - p0 !== 3) begin n_bad++; $display("FAIL stp3_pops: got %0d expected 3", ndpop - p0); end
    n_cmp++; if (st_cyc[s0] !== dpop_cyc[p0 + 2] + 1) begin
      n_bad++; $display("FAIL stp3_status_cycle: got %0d expected %0d", st_cyc[s0], dpop_cyc[p0 + 2] + 1); end
    n_cmp++; if (nres !== r0) begin n_bad++; $display("FAIL stp3_no_result: got %0d results expected %0d", nres, r0); end
    s0 = nstat; p0 = ndpop;
    push_data(16'd2);
    push_cmd(16'h0001);
    wait_status(s0, ok);
    n_cmp++; if (!ok || nres - r0 !== 1 || res_val[r0] !== 16'd17) begin
      n_bad++; $display("FAIL evp_result: got %0h (%0d pushes) expected 11 (1 push)", res_val[r0], nres - r0); end
    n_cmp++; if (res_cyc[r0] !== dpop_cyc[p0] + 3) begin
      n_bad++; $display("FAIL evp_latency: got %0d expected %0d", res_cyc[r0], dpop_cyc[p0] + 3); end
    n_cmp++; if (st_val[s0] !== 16'd0 || st_cyc[s0] !== res_cyc[r0]) begin
      n_bad++; $display("FAIL evp_status: got %0h@%0d expected 0@%0d", st_val[s0], st_cyc[s0], res_cyc[r0]); end
    n_cmp++; if (next_mode_out !== 2'b01) begin n_bad++; $display("FAIL evp_mode_at_push: got %0h expected 1", next_mode_out); end
    @(negedge clk); #1;
    n_cmp++; if (next_mode_out !== 2'b00) begin n_bad++; $display("FAIL evp_return_setup: got %0h expected 0", next_mode_out); end
    n_cmp++; if (mode_out !== 8'd1 || arg2_out !== 5'd0) begin
      n_bad++; $display("FAIL evp_latched: got %0h/%0h expected 1/0", mode_out, arg2_out); end
  endtask

  task automatic test_evb();
    int s0, r0, p0; bit ok;
    s0 = nstat; r0 = nres; p0 = ndpop;
    push_data(16'd0); push_data(16'd1);
    push_cmd(16'h0202);
    wait_status(s0, ok);
    n_cmp++; if (!ok || nres - r0 !== 2 || res_val[r0] !== 16'd1 || res_val[r0 + 1] !== 16'd6) begin
      n_bad++; $display("FAIL evb_results: got %0h,%0h (%0d pushes) expected 1,6", res_val[r0], res_val[r0 + 1], nres - r0); end
    n_cmp++; if (nstat - s0 !== 1 || st_val[s0] !== 16'd2 || st_cyc[s0] !== res_cyc[r0 + 1]) begin
      n_bad++; $display("FAIL evb_status: got %0h@%0d (%0d pushes) expected 2@%0d", st_val[s0], st_cyc[s0], nstat - s0, res_cyc[r0 + 1]); end
    n_cmp++; if (dpop_cyc[p0 + 1] !== res_cyc[r0] + 1) begin
      n_bad++; $display("FAIL evb_second_pop: got %0d expected %0d", dpop_cyc[p0 + 1], res_cyc[r0] + 1); end
  endtask

  task automatic test_overflow();
    int s0, r0, p0; bit ok;
    s0 = nstat;
    push_data(16'd1); push_data(16'h8000);
    push_cmd(16'h0200);
    wait_status(s0, ok);
    n_cmp++; if (!ok || st_val[s0] !== 16'd2) begin n_bad++; $display("FAIL ovf_stp_status: got %0h expected 2", st_val[s0]); end
    s0 = nstat; r0 = nres; p0 = ndpop;
    push_data(16'd2);
    push_cmd(16'h0001);
    wait_status(s0, ok);
    n_cmp++; if (!ok || res_val[r0] !== 16'h0001 || res_cyc[r0] !== dpop_cyc[p0] + 2) begin
      n_bad++; $display("FAIL ovf_result: got %0h@%0d expected 1@%0d", res_val[r0], res_cyc[r0], dpop_cyc[p0] + 2); end
  endtask

  task automatic test_errors();
    int s0, r0, p0; bit ok;
    s0 = nstat; r0 = nres; p0 = ndpop;
    push_cmd(16'h0007);
    wait_status(s0, ok);
    n_cmp++; if (!ok || st_val[s0] !== 16'hFFFF || ndpop !== p0 || nres !== r0) begin
      n_bad++; $display("FAIL bad_mode: got %0h pops %0d expected ffff pops 0", st_val[s0], ndpop - p0); end
    s0 = nstat;
    for (int i = 0; i < 20; i++) push_data(16'(100 + i));
    push_cmd(16'h1400);
    wait_status(s0, ok);
    n_cmp++; if (!ok || st_val[s0] !== 16'hFFFE || ndpop - p0 !== 20 || nres !== r0) begin
      n_bad++; $display("FAIL stp20: got %0h pops %0d expected fffe pops 20", st_val[s0], ndpop - p0); end
    s0 = nstat;
    push_data(16'd3);
    push_cmd(16'h0001);
    wait_status(s0, ok);
    n_cmp++; if (!ok || res_val[r0] !== 16'h8001) begin
      n_bad++; $display("FAIL poly_kept: got %0h expected 8001", res_val[r0]); end
  endtask

  task automatic test_reset_mid_evb();
    int s0, r0, p0; bit ok;
    s0 = nstat;
    push_data(16'd1); push_data(16'd2); push_data(16'd3);
    push_cmd(16'h0300);
    wait_status(s0, ok);
    s0 = nstat; r0 = nres; p0 = ndpop;
    push_data(16'd2); push_data(16'd3);
    push_cmd(16'h0202);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (ndpop > p0) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_pop_timeout: got no x pop expected one"); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (nres !== r0 || nstat !== s0) begin
      n_bad++; $display("FAIL mid_no_push: got %0d results %0d status expected 0/0", nres - r0, nstat - s0); end
    n_cmp++; if (next_mode_out !== 2'b00 || mode_out !== 8'd0) begin
      n_bad++; $display("FAIL mid_state: got %0h/%0h expected 0/0", next_mode_out, mode_out); end
    push_cmd(16'h0001);
    wait_status(s0, ok);
    n_cmp++; if (!ok || st_val[s0] !== 16'hFFFD || nres !== r0 || ndpop - p0 !== 2) begin
      n_bad++; $display("FAIL mid_evp_empty: got %0h results %0d pops %0d expected fffd 0 2", st_val[s0], nres - r0, ndpop - p0); end
  endtask

  initial begin
    test_reset();
    test_stp_evp();
    test_evb();
    test_overflow();
    test_errors();
    test_reset_mid_evb();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
